dsm_sample_buffer: RTL

//  Sample-rate buffer between the sample source and the delta-sigma modulator (DSM).

---
 rtl/dsm_sample_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/dsm_sample_buffer.sv
// Sample-rate buffer feeding the delta-sigma modulator: a small FIFO filled by a
// valid/ready source and drained one sample per 1 MHz strobe into a held register.
module dsm_sample_buffer #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk50m,
  input  logic          rst_n,
  input  logic          en50m_1m_i,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  output logic [DW-1:0] smp_out_o,
  output logic          smp_upd_o,
  output logic [AW:0]   fill_o,
  input  logic          underrun_clr_i,
  output logic          underrun_flag_o,
  output logic [7:0]    underrun_cnt_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [DW-1:0] smp_q, smp_d;
  logic          upd_q, upd_d;
  logic          flag_q, flag_d;
  logic [7:0]    cnt_q, cnt_d;

  logic full, push, pop, underrun;

  // Push and pop both look only at the registered fill, so a sample pushed into
  // an empty FIFO cannot leave on the same strobe.
  assign full     = (fill_q == (AW+1)'(DEPTH));
  assign push     = s_valid_i & ~full;
  assign pop      = en50m_1m_i & (fill_q != '0);
  assign underrun = en50m_1m_i & (fill_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    smp_d    = smp_q;
    upd_d    = 1'b0;
    flag_d   = flag_q;
    cnt_d    = cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      smp_d    = mem_q[rd_ptr_q];
      upd_d    = 1'b1;
    end

    case ({push, pop})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase

    // A clear coinciding with an underrun still records that underrun.
    if (underrun) begin
      flag_d = 1'b1;
      if (underrun_clr_i)      cnt_d = 8'd1;
      else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end else if (underrun_clr_i) begin
      flag_d = 1'b0;
      cnt_d  = 8'd0;
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      smp_q    <= '0;
      upd_q    <= 1'b0;
      flag_q   <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      smp_q    <= smp_d;
      upd_q    <= upd_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk50m) begin
    if (push) mem_q[wr_ptr_q] <= s_data_i;
  end

  assign s_ready_o       = ~full;
  assign smp_out_o       = smp_q;
  assign smp_upd_o       = upd_q;
  assign fill_o          = fill_q;
  assign underrun_flag_o = flag_q;
  assign underrun_cnt_o  = cnt_q;

endmodule
